// File: rtl/dac_interp.sv
// Linear-interpolating DAC feeder: one-entry input buffer, per-tick accumulator stepping from prev to cur.
// Optional build macro DAC_INTERP_ROUND_EN selects round-half-up RUN output instead of truncation.
module dac_interp #(
   parameter int unsigned DAC_WIDTH         = 8,
   parameter int unsigned INTERP_DEPTH_BITS = 4
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 sample_in,
   input  logic [DAC_WIDTH-1:0] data_in,
   output logic                 in_ready,
   input  logic                 out_tick,
   output logic [DAC_WIDTH-1:0] data_out,
   output logic                 data_out_valid,
   output logic                 underrun
);

   localparam int unsigned W  = DAC_WIDTH;
   localparam int unsigned N  = INTERP_DEPTH_BITS;
   localparam int unsigned DW = W + 1;
   localparam int unsigned AW = W + N + 1;
   localparam logic [N-1:0] PHASE_LAST = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      STALL = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [W-1:0]    prev, prev_nxt;
   logic [W-1:0]    cur, cur_nxt;
   logic [DW-1:0]   delta, delta_nxt;
   logic [AW-1:0]   acc, acc_nxt;
   logic [N-1:0]    phase, phase_nxt;
   logic            buf_full, buf_full_nxt;
   logic [W-1:0]    buf_data, buf_data_nxt;
   logic [W-1:0]    dout_nxt;
   logic            valid_nxt;
   logic            under_nxt;

   logic            accept;
   logic            seg_start;
   logic [AW-1:0]   delta_ext;
   logic [AW-1:0]   acc_out;
   logic [W-1:0]    run_out;

   assign in_ready  = ~buf_full;
   assign accept    = sample_in & ~buf_full;
   assign delta_ext = {{N{delta[DW-1]}}, delta};

`ifdef DAC_INTERP_ROUND_EN
   localparam logic [AW-1:0] ROUND_BIAS = AW'(1) << (N - 1);
   assign acc_out = acc + ROUND_BIAS;
`else
   assign acc_out = acc;
`endif

   assign run_out = W'(acc_out >> N);

   // Next-state and datapath: segment-end decisions use buffer state at cycle start
   always_comb begin
      state_nxt    = state;
      prev_nxt     = prev;
      cur_nxt      = cur;
      delta_nxt    = delta;
      acc_nxt      = acc;
      phase_nxt    = phase;
      buf_full_nxt = buf_full;
      buf_data_nxt = buf_data;
      dout_nxt     = data_out;
      valid_nxt    = 1'b0;
      under_nxt    = 1'b0;
      seg_start    = 1'b0;

      // Outside IDLE an accepted sample is only buffered, never bypassed
      if (state != IDLE && accept) begin
         buf_full_nxt = 1'b1;
         buf_data_nxt = data_in;
      end

      case (state)
         IDLE: begin
            if (accept) begin
               prev_nxt  = data_in;
               cur_nxt   = data_in;
               delta_nxt = '0;
               acc_nxt   = AW'(data_in) << N;
               phase_nxt = '0;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (out_tick) begin
               dout_nxt  = run_out;
               valid_nxt = 1'b1;
               acc_nxt   = acc + delta_ext;
               phase_nxt = phase + N'(1);
               if (phase == PHASE_LAST) begin
                  if (buf_full) seg_start = 1'b1;
                  else          state_nxt = STALL;
               end
            end
         end
         STALL: begin
            if (out_tick) begin
               dout_nxt  = cur;
               valid_nxt = 1'b1;
               under_nxt = 1'b1;
            end
            if (buf_full) begin
               seg_start = 1'b1;
               state_nxt = RUN;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // New segment: old cur becomes the start point, buffered sample the target
      if (seg_start) begin
         prev_nxt     = cur;
         cur_nxt      = buf_data;
         delta_nxt    = {1'b0, buf_data} - {1'b0, cur};
         acc_nxt      = AW'(cur) << N;
         phase_nxt    = '0;
         buf_full_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state          <= IDLE;
         prev           <= '0;
         cur            <= '0;
         delta          <= '0;
         acc            <= '0;
         phase          <= '0;
         buf_full       <= 1'b0;
         buf_data       <= '0;
         data_out       <= '0;
         data_out_valid <= 1'b0;
         underrun       <= 1'b0;
      end else begin
         // Interpolated output must stay within the segment end points
         if (state == RUN && out_tick)
            assert ((run_out >= prev && run_out <= cur) || (run_out <= prev && run_out >= cur));
         state          <= state_nxt;
         prev           <= prev_nxt;
         cur            <= cur_nxt;
         delta          <= delta_nxt;
         acc            <= acc_nxt;
         phase          <= phase_nxt;
         buf_full       <= buf_full_nxt;
         buf_data       <= buf_data_nxt;
         data_out       <= dout_nxt;
         data_out_valid <= valid_nxt;
         underrun       <= under_nxt;
      end
   end

endmodule

// File: tb/tb_dac_interp.sv
// Directed bench for dac_interp with DAC_WIDTH=8, INTERP_DEPTH_BITS=2; inputs driven and outputs checked on negedge.
module tb_dac_interp;

   logic       clk;
   logic       rstn;
   logic       sample_in;
   logic [7:0] data_in;
   logic       in_ready;
   logic       out_tick;
   logic [7:0] data_out;
   logic       data_out_valid;
   logic       underrun;

   int n_checks = 0;
   int n_err    = 0;

   dac_interp #(.DAC_WIDTH(8), .INTERP_DEPTH_BITS(2)) dut (
      .clk            (clk),
      .rstn           (rstn),
      .sample_in      (sample_in),
      .data_in        (data_in),
      .in_ready       (in_ready),
      .out_tick       (out_tick),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .underrun       (underrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One-cycle sample strobe, called at a negedge
   task automatic push(input logic [7:0] x);
      sample_in = 1'b1;
      data_in   = x;
      @(negedge clk);
      sample_in = 1'b0;
   endtask

   // One-cycle out_tick, then check the registered response
   task automatic tick(input string tag, input int exp_d, input int exp_v, input int exp_u);
      out_tick = 1'b1;
      @(negedge clk);
      out_tick = 1'b0;
      chk({tag, "_valid"}, int'(data_out_valid), exp_v);
      chk({tag, "_under"}, int'(underrun), exp_u);
      chk({tag, "_data"}, int'(data_out), exp_d);
   endtask

   initial begin
      int r3 [4];
`ifdef DAC_INTERP_ROUND_EN
      r3 = '{0, 1, 2, 2};
`else
      r3 = '{0, 0, 1, 2};
`endif
      rstn      = 1'b0;
      sample_in = 1'b0;
      data_in   = 8'd0;
      out_tick  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_data", int'(data_out), 0);
      chk("rst_valid", int'(data_out_valid), 0);
      chk("rst_under", int'(underrun), 0);
      chk("rst_ready", int'(in_ready), 1);
      rstn = 1'b1;
      @(negedge clk);

      // IDLE ignores ticks
      tick("idle_tick", 0, 0, 0);

      // Samples 0 then 100: flat segment, then ramp to 100
      push(8'd0);
      push(8'd100);
      chk("buf_full_ready", int'(in_ready), 0);
      tick("s0_t0", 0, 1, 0);
      tick("s0_t1", 0, 1, 0);
      tick("s0_t2", 0, 1, 0);
      tick("s0_t3", 0, 1, 0);
      chk("seg_load_ready", int'(in_ready), 1);
      push(8'd40);
      tick("s1_t0", 0, 1, 0);
      tick("s1_t1", 25, 1, 0);
      tick("s1_t2", 50, 1, 0);
      tick("s1_t3", 75, 1, 0);
      @(negedge clk);
      chk("valid_one_cycle", int'(data_out_valid), 0);

      // Falling segment 100 -> 40, then stall with no new sample
      tick("s2_t0", 100, 1, 0);
      tick("s2_t1", 85, 1, 0);
      tick("s2_t2", 70, 1, 0);
      tick("s2_t3", 55, 1, 0);
      tick("stall_0", 40, 1, 1);
      tick("stall_1", 40, 1, 1);
      tick("stall_2", 40, 1, 1);

      // Sample arrives; a tick in the restart cycle is still a stall tick
      push(8'd200);
      tick("stall_restart", 40, 1, 1);
      tick("s3_t0", 40, 1, 0);
      tick("s3_t1", 80, 1, 0);
      tick("s3_t2", 120, 1, 0);
      tick("s3_t3", 160, 1, 0);

      // Start segment 200 -> 7 and reset partway through
      push(8'd7);
      @(negedge clk);
      tick("s4_t0", 200, 1, 0);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      chk("mid_rst_data", int'(data_out), 0);
      chk("mid_rst_valid", int'(data_out_valid), 0);
      chk("mid_rst_under", int'(underrun), 0);
      chk("mid_rst_ready", int'(in_ready), 1);
      tick("post_rst_tick0", 0, 0, 0);
      tick("post_rst_tick1", 0, 0, 0);

      // sample_in held high: 0 loads, 3 buffers, 99 is dropped
      sample_in = 1'b1;
      data_in   = 8'd0;
      @(negedge clk);
      data_in = 8'd3;
      @(negedge clk);
      chk("hold_ready_0", int'(in_ready), 0);
      data_in = 8'd99;
      @(negedge clk);
      chk("hold_ready_1", int'(in_ready), 0);
      tick("h0_t0", 0, 1, 0);
      tick("h0_t1", 0, 1, 0);
      chk("hold_ready_2", int'(in_ready), 0);
      tick("h0_t2", 0, 1, 0);
      tick("h0_t3", 0, 1, 0);
      sample_in = 1'b0;
      chk("hold_seg_end_ready", int'(in_ready), 1);

      // Segment 0 -> 3 exercises truncation vs rounding
      tick("h1_t0", r3[0], 1, 0);
      tick("h1_t1", r3[1], 1, 0);
      tick("h1_t2", r3[2], 1, 0);
      tick("h1_t3", r3[3], 1, 0);
      tick("h_stall_0", 3, 1, 1);
      @(negedge clk);
      tick("h_stall_1", 3, 1, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
